rx_bit_deser: RTL and testbench

Receive-side consumer of the quarter-bit baud generator. Synchronises the async bus RX line, detects a start bit, re-aligns the baud generator with a one-cycle sync pulse, samples each bit at mid-bit (quarter phase 2), and assembles UART-style 8N1 frames (LSB first) into bytes. Reports a framing error on a bad stop bit, and reports bus-idle after a programmable number of idle bit times; the frame layer above uses bus-idle for packet delimiting.

---
 rtl/rx_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/rx_bit_deser.sv | 149 ++++++++++++++
 tb/tb_rx_bit_deser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-side bit deserialiser.
package rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    localparam logic [1:0] PH_SAMPLE   = 2'd2;
    localparam logic [1:0] PH_BOUNDARY = 2'd0;
    localparam int         RX_DATA_W   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, reset value chosen per use
// so an idle-high line does not look like activity coming out of reset.
module sync_2ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_bit_deser.sv
// 8N1 receiver driven by a quarter-bit baud generator: start detection with
// generator re-alignment, mid-bit sampling, framing error and bus-idle report.
module rx_bit_deser
    import rx_pkg::*;
#(
    parameter int IDLE_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic [1:0]           baud_cnt,
    input  logic                 baud_inc,
    output logic                 baud_sync,
    output logic [RX_DATA_W-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 bus_idle
);

    localparam logic [8:0] IDLE_LIM = 9'(IDLE_BITS);

    logic                 rx_s;
    logic                 rx_d;
    logic                 fall;
    logic                 mid_bit;
    logic                 bit_edge;
    rx_state_t            state;
    logic [2:0]           bit_idx;
    logic [RX_DATA_W-1:0] shift_reg;
    logic [7:0]           idle_cnt;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_d <= 1'b1;
        end else begin
            rx_d <= rx_s;
        end
    end

    assign fall     = rx_d & ~rx_s;
    assign mid_bit  = baud_inc && (baud_cnt == PH_SAMPLE);
    assign bit_edge = baud_inc && (baud_cnt == PH_BOUNDARY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bit_idx    <= 3'd0;
            shift_reg  <= '0;
            idle_cnt   <= 8'd0;
            baud_sync  <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            bus_idle   <= 1'b0;
        end else begin
            baud_sync  <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state != S_IDLE) begin
                idle_cnt <= 8'd0;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        baud_sync <= 1'b1;
                        bus_idle  <= 1'b0;
                        idle_cnt  <= 8'd0;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end else if (!rx_s) begin
                        idle_cnt <= 8'd0;
                    end else if (bit_edge) begin
                        if (idle_cnt != 8'hFF) begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                        if (({1'b0, idle_cnt} + 9'd1) >= IDLE_LIM) begin
                            bus_idle <= 1'b1;
                        end
                    end
                end

                // The generator is being zeroed while baud_sync is high, so any
                // phase it reports in that cycle is stale.
                S_START: begin
                    if (mid_bit && !baud_sync) begin
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (mid_bit) begin
                        shift_reg <= {rx_s, shift_reg[RX_DATA_W-1:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end

                // Returning to IDLE mid-stop-bit lets a start edge in the
                // second half of the stop bit begin the next frame.
                S_STOP: begin
                    if (mid_bit) begin
                        busy <= 1'b0;
                        if (rx_s) begin
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end
                    end
                end

                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_deser.sv
// Bench for rx_bit_deser with a behavioural quarter-bit baud generator (Q=5,
// 20 clocks per bit) and a frame-level scoreboard of expected bytes/errors.
module tb_rx_bit_deser;

    localparam int Q        = 5;
    localparam int BIT_CLKS = 4 * Q;

    typedef struct {
        logic       is_err;
        logic [7:0] value;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [1:0] baud_cnt;
    logic       baud_inc;
    logic       baud_sync;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       bus_idle;

    int   vectors     = 0;
    int   miscompares = 0;
    int   sync_cnt    = 0;
    int   presc;
    logic [7:0] exp_data = 8'h00;
    exp_t sb_q[$];

    rx_bit_deser #(.IDLE_BITS(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .baud_cnt   (baud_cnt),
        .baud_inc   (baud_inc),
        .baud_sync  (baud_sync),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .bus_idle   (bus_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quarter-bit generator: baud_inc pulses every Q clocks with baud_cnt
    // already advanced; baud_sync zeroes it so the first phase-2 pulse lands
    // 2Q clocks after the sync cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= 0;
            baud_cnt <= 2'd0;
            baud_inc <= 1'b0;
        end else if (baud_sync) begin
            presc    <= 0;
            baud_cnt <= 2'd0;
            baud_inc <= 1'b0;
        end else begin
            baud_inc <= 1'b0;
            if (presc == Q - 1) begin
                presc <= 0;
            end else begin
                presc <= presc + 1;
                if (presc == Q - 2) begin
                    baud_inc <= 1'b1;
                    baud_cnt <= baud_cnt + 2'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (baud_sync) sync_cnt++;
            if (data_valid && frame_err) check("dv_fe_exclusive", 1, 0);
            if (data_valid || frame_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, data_valid, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    check("busy_at_pulse", {31'd0, busy}, 0);
                    if (!e.is_err) check("rx_byte", {24'd0, data}, {24'd0, e.value});
                    $display("frame: kind=%s data=0x%02h expected=0x%02h",
                             e.is_err ? "ferr" : "byte", data, e.value);
                end
            end
        end
    end

    task automatic drive_level(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a whole frame and records the outcome the receiver must report.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        exp_t e;
        e.is_err = ~stop;
        e.value  = b;
        sb_q.push_back(e);
        if (stop) exp_data = b;
        drive_level(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_level(b[i], BIT_CLKS);
        drive_level(stop, stop_len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_baud_sync"}, {31'd0, baud_sync}, 0);
        check({tag, "_data"}, {24'd0, data}, 0);
        check({tag, "_data_valid"}, {31'd0, data_valid}, 0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_bus_idle"}, {31'd0, bus_idle}, 0);
    endtask

    initial begin
        int base;
        int n_edge;
        logic got;
        logic [7:0] b;
        logic stop;

        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Bus idle after ten bit boundaries of high RX.
        n_edge = 0;
        for (int c = 0; c < 400 && n_edge < 10; c++) begin
            @(negedge clk);
            if (baud_inc && baud_cnt == 2'd0) n_edge++;
        end
        check("idle_edge_budget", n_edge, 10);
        check("bus_idle_before", {31'd0, bus_idle}, 0);
        @(negedge clk);
        check("bus_idle_after", {31'd0, bus_idle}, 1);
        @(posedge clk);
        #1;

        // Clean 0xA5; bus_idle must drop in the baud_sync cycle.
        base = sync_cnt;
        fork
            send_frame(8'hA5, 1'b1, BIT_CLKS);
            begin
                got = 1'b0;
                for (int c = 0; c < 10 && !got; c++) begin
                    @(negedge clk);
                    if (baud_sync) begin
                        got = 1'b1;
                        check("bus_idle_at_sync", {31'd0, bus_idle}, 0);
                        check("busy_at_sync", {31'd0, busy}, 1);
                    end
                end
                check("sync_seen", {31'd0, got}, 1);
            end
        join
        drive_level(1'b1, 2 * BIT_CLKS);
        check("data_hold_a5", {24'd0, data}, {24'd0, exp_data});

        // Short low glitch: one sync, no pulse, data unchanged.
        base = sync_cnt;
        drive_level(1'b0, 3);
        drive_level(1'b1, 3 * BIT_CLKS);
        check("glitch_syncs", sync_cnt - base, 1);
        check("glitch_busy", {31'd0, busy}, 0);
        check("glitch_data", {24'd0, data}, {24'd0, exp_data});

        // Bad stop bit with RX held low two more bits: no restart while low.
        base = sync_cnt;
        send_frame(8'h3C, 1'b0, BIT_CLKS);
        drive_level(1'b0, 2 * BIT_CLKS);
        check("ferr_no_restart_low", sync_cnt - base, 1);
        drive_level(1'b1, 2 * BIT_CLKS);
        check("ferr_no_restart_high", sync_cnt - base, 1);
        check("ferr_data_kept", {24'd0, data}, {24'd0, exp_data});
        send_frame(8'h96, 1'b1, BIT_CLKS);
        drive_level(1'b1, BIT_CLKS);

        // Back-to-back: next start lands in the second half of the stop bit.
        send_frame(8'h00, 1'b1, 15);
        send_frame(8'hFF, 1'b1, BIT_CLKS);
        drive_level(1'b1, BIT_CLKS);
        check("b2b_last_data", {24'd0, data}, 8'hFF);

        // Randomised frames with occasional framing errors.
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, BIT_CLKS);
            if (!stop) drive_level(1'b0, BIT_CLKS);
            drive_level(1'b1, $urandom_range(BIT_CLKS, 3 * BIT_CLKS));
        end

        // Reset during bit 4 aborts the frame.
        drive_level(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_level(i[0], BIT_CLKS);
        drive_level(1'b1, 10);
        check("busy_mid_frame", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_data = 8'h00;
        drive_level(1'b1, 3);
        reset_n = 1'b1;
        drive_level(1'b1, 3 * BIT_CLKS);
        check("post_reset_data", {24'd0, data}, 0);
        send_frame(8'hC3, 1'b1, BIT_CLKS);
        drive_level(1'b1, 2 * BIT_CLKS);
        check("final_data", {24'd0, data}, 8'hC3);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
